fetch_stage: RTL and testbench

//  Instruction fetch stage of the darkriscv core; sits directly upstream of the decoder.

---
 rtl/darkriscv_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/darkriscv_pkg.sv
// Shared types and constants for the darkriscv front end (fetch stage and decoder).
package darkriscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    // Major opcodes, shared with the decoder
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BCC   = 7'b1100011;
    localparam logic [6:0] OPC_LCC   = 7'b0000011;
    localparam logic [6:0] OPC_SCC   = 7'b0100011;
    localparam logic [6:0] OPC_MCC   = 7'b0010011;
    localparam logic [6:0] OPC_RCC   = 7'b0110011;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with clear; a pop and a push may share a cycle even when full.
module fetch_queue #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// darkriscv instruction fetch: PC, in-order bus requests, prefetch queue, decoder flush/xreset.
// Optional FETCH_PERF_EN adds saturating stall and drop counters.
module fetch_stage
    import darkriscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned QDEPTH       = 2,
    parameter int unsigned XRES_CYCLES  = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hlt,
    input  logic        redir,
    input  logic [31:0] redir_pc,
    output logic        ireq,
    output logic [31:0] iaddr,
    input  logic        igrant,
    input  logic        ivalid,
    input  logic [31:0] idata,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        flush,
    output logic        xreset
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_stall_cnt,
    output logic [31:0] fetch_drop_cnt
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned XW = $clog2(XRES_CYCLES + 2);
    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 2);

    logic [31:0]   pc;
    logic [CW-1:0] discard;
    logic [FW-1:0] flush_cnt;
    logic [XW-1:0] xres_cnt;

    logic [CW-1:0] dq_count;
    logic [CW-1:0] aq_count;
    logic [SW-1:0] inflight;
    fetch_entry_t  dq_in;
    fetch_entry_t  dq_head;
    logic [31:0]   aq_head;
    logic          dq_empty;
    logic          grant;
    logic          drop;
    logic          dq_push;
    logic          dq_pop;

    assign inflight = SW'(dq_count) + SW'(aq_count);
    assign ireq     = !rst & (inflight < SW'(QDEPTH)) & !redir;
    assign iaddr    = pc;
    assign grant    = ireq & igrant;
    assign drop     = ivalid & (discard != '0);
    assign dq_push  = ivalid & !drop;
    assign dq_empty = (dq_count == '0);
    assign dq_pop   = !dq_empty & !hlt & !redir;
    assign dq_in    = '{data: idata, pc: aq_head};

    // Addresses of outstanding requests; its occupancy is the outstanding count
    fetch_queue #(.W(32), .DEPTH(QDEPTH)) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (grant),
        .push_data (pc),
        .pop       (ivalid),
        .head      (aq_head),
        .count     (aq_count)
    );

    fetch_queue #(.W(ENTRY_W), .DEPTH(QDEPTH)) u_data_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redir),
        .push      (dq_push),
        .push_data (dq_in),
        .pop       (dq_pop),
        .head      (dq_head),
        .count     (dq_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            discard   <= '0;
            flush_cnt <= '0;
            xres_cnt  <= XW'(XRES_CYCLES);
        end else begin
            if (redir) begin
                // Everything still in flight after this cycle belongs to the old path
                pc        <= redir_pc;
                discard   <= aq_count - CW'(ivalid);
                flush_cnt <= FW'(FLUSH_CYCLES);
            end else begin
                if (grant)              pc        <= pc + 32'd4;
                if (drop)               discard   <= discard - CW'(1);
                if (flush_cnt != '0)    flush_cnt <= flush_cnt - FW'(1);
            end
            if (xres_cnt != '0) xres_cnt <= xres_cnt - XW'(1);
        end
    end

    assign xreset  = rst | (xres_cnt != '0);
    assign flush   = (flush_cnt != '0) | dq_empty | xreset;
    assign insn    = dq_empty ? NOP_INSN : dq_head.data;
    assign insn_pc = dq_empty ? pc : dq_head.pc;

`ifdef FETCH_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_stall_cnt <= '0;
            fetch_drop_cnt  <= '0;
        end else begin
            if (!xreset && dq_empty && !hlt && (fetch_stall_cnt != '1))
                fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
            if (drop && (fetch_drop_cnt != '1))
                fetch_drop_cnt <= fetch_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random bus slave, program-order stream scoreboard, directed corner cases.
module tb_fetch_stage;
    import darkriscv_pkg::*;

    localparam int unsigned QD  = 3;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst, hlt, redir, igrant, ivalid;
    logic [31:0] redir_pc, idata;
    logic        ireq, flush, xreset;
    logic [31:0] iaddr, insn, insn_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_stall_cnt, fetch_drop_cnt;
`endif

    fetch_stage #(.RESET_PC(RPC), .QDEPTH(QD), .XRES_CYCLES(2), .FLUSH_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .hlt      (hlt),
        .redir    (redir),
        .redir_pc (redir_pc),
        .ireq     (ireq),
        .iaddr    (iaddr),
        .igrant   (igrant),
        .ivalid   (ivalid),
        .idata    (idata),
        .insn     (insn),
        .insn_pc  (insn_pc),
        .flush    (flush),
        .xreset   (xreset)
`ifdef FETCH_PERF_EN
        ,
        .fetch_stall_cnt (fetch_stall_cnt),
        .fetch_drop_cnt  (fetch_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned rdy;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t sb[$];
    int           total = 0;
    int           bad = 0;
    int           deliveries = 0;
    int unsigned  cyc = 0;
    int unsigned  lat_min = 1, lat_max = 1, grant_pct = 100;
    logic [31:0]  gen_pc = RPC;

    // memory[i] = i (word index)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic topup();
        while (sb.size() < 16) begin
            sb.push_back('{data: mem_word(gen_pc), pc: gen_pc});
            gen_pc += 32'd4;
        end
    endtask

    // A new program-order stream starts at p; anything older is no longer expected
    task automatic restart(input logic [31:0] p);
        sb.delete();
        gen_pc = p;
        topup();
    endtask

    task automatic cycle(input logic r, input logic h, input logic d, input logic [31:0] dpc);
        @(posedge clk);
        #1;
        cyc++;
        rst      = r;
        hlt      = h;
        redir    = d & !r;
        redir_pc = dpc;
        if (r) restart(RPC);
        else if (d) restart(dpc);
        topup();
        if (r) begin
            ivalid = 1'b0;
            idata  = 32'h0;
        end else if (pend.size() > 0 && pend[0].rdy <= cyc) begin
            ivalid = 1'b1;
            idata  = mem_word(pend[0].addr);
        end else begin
            ivalid = 1'b0;
            idata  = 32'hDEAD_BEEF;
        end
        igrant = ($urandom_range(99) < grant_pct);
        @(negedge clk);
        if (rst) pend.delete();
        else begin
            if (ivalid) void'(pend.pop_front());
            if (ireq && igrant)
                pend.push_back('{addr: iaddr, rdy: cyc + $urandom_range(lat_max, lat_min)});
        end
    endtask

    // Every unflushed slot must be the next word of the current stream
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && redir === 1'b0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL stream_empty actual=%h@%h required=none", insn, insn_pc);
            end else begin
                if (insn !== sb[0].data || insn_pc !== sb[0].pc) begin
                    bad++;
                    $display("FAIL stream actual=%h@%h required=%h@%h (cycle %0d)",
                             insn, insn_pc, sb[0].data, sb[0].pc, cyc);
                end
                if (!hlt) begin
                    void'(sb.pop_front());
                    deliveries++;
                end
            end
        end
    end

    initial begin
        int  d0;
        bit  seen, done;
        logic [31:0] rpc;

        rst = 1'b1; hlt = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        igrant = 1'b0; ivalid = 1'b0; idata = 32'h0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            chk("rst_ireq", 32'(ireq), 32'd0);
            chk("rst_insn", insn, NOP_INSN);
            chk("rst_insn_pc", insn_pc, RPC);
            chk("rst_flush", 32'(flush), 32'd1);
            chk("rst_xreset", 32'(xreset), 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("x0_xreset", 32'(xreset), 32'd1);
        chk("x0_ireq", 32'(ireq), 32'd1);
        chk("x0_iaddr", iaddr, RPC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("x1_xreset", 32'(xreset), 32'd1);
        chk("x1_flush", 32'(flush), 32'd1);
        chk("x1_insn", insn, NOP_INSN);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("x2_xreset", 32'(xreset), 32'd0);

        // Streaming: one insn per cycle
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (i >= 2) chk("steady_flush", 32'(flush), 32'd0);
        end

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (i >= 1) chk("hlt_ireq", 32'(ireq), 32'd0);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect with requests in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pend.size() < 2; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_inflight", 32'(pend.size() >= 2), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h100);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_flush1", 32'(flush), 32'd1);
        done = 1'b0;
        if (ireq) begin chk("redir_iaddr", iaddr, 32'h100); done = 1'b1; end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_flush2", 32'(flush), 32'd1);
        for (int i = 0; i < 12 && !done; i++) begin
            if (ireq) begin chk("redir_iaddr", iaddr, 32'h100); done = 1'b1; end
            else cycle(1'b0, 1'b0, 1'b0, 32'h0);
        end
        if (!done) chk("redir_iaddr_timeout", 32'd0, 32'd1);
        d0 = deliveries;
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_progress", 32'(deliveries - d0 >= 3), 32'd1);

        // Redirect under hlt, then reset mid-flight
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("hlt_redir_ireq", 32'(ireq), 32'd1);
        chk("hlt_redir_iaddr", iaddr, 32'h200);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("mid_rst_ireq", 32'(ireq), 32'd0);
        chk("mid_rst_xreset", 32'(xreset), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_rst_iaddr", iaddr, RPC);
        chk("post_rst_insn", insn, NOP_INSN);
        chk("post_rst_insn_pc", insn_pc, RPC);
        chk("post_rst_xreset0", 32'(xreset), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_rst_xreset1", 32'(xreset), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_rst_xreset2", 32'(xreset), 32'd0);

        // PC wrap-around
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (ireq && igrant) begin
                if (!seen) begin
                    chk("wrap_first", iaddr, 32'hFFFF_FFFC);
                    seen = 1'b1;
                end else begin
                    chk("wrap_next", iaddr, 32'h0);
                    done = 1'b1;
                end
            end
        end
        if (!done) chk("wrap_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic
        lat_min = 1; lat_max = 4; grant_pct = 70;
        d0 = deliveries;
        for (int i = 0; i < 800; i++) begin
            rpc = $urandom() & 32'hFFFF_FFFC;
            cycle($urandom_range(199) == 0, $urandom_range(3) == 0,
                  $urandom_range(24) == 0, rpc);
        end
        rst = 1'b0;
        chk("rand_progress", 32'(deliveries - d0 > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
